// File: rtl/br_resolve_pkg.sv
// rtl/br_resolve_pkg.sv - shared types and constants for the branch resolution stage
//
// Contents:
//   BR_W, BR_ADDR_W - operand and PC widths that the payload structs are built on
//   BR_INSN_BYTES   - fall-through distance between sequential branch PCs
//   cond_t          - 3-bit branch condition code
//   s1_pl_t         - operand-register payload (cond, a, b, pc, target, pred_taken)
//   s2_res_t        - result-register payload (taken, mispredict, redirect_pc)
//   seq_pc()        - fall-through PC, wraps modulo 2^BR_ADDR_W

package br_resolve_pkg;

   localparam int unsigned BR_W          = 32;
   localparam int unsigned BR_ADDR_W     = 32;
   localparam int unsigned BR_INSN_BYTES = 4;

   typedef enum logic [2:0] {
      COND_EQ     = 3'b000,
      COND_NE     = 3'b001,
      COND_ALWAYS = 3'b010,
      COND_NEVER  = 3'b011,
      COND_LT     = 3'b100,
      COND_GE     = 3'b101,
      COND_LTU    = 3'b110,
      COND_GEU    = 3'b111
   } cond_t;

   typedef struct packed {
      cond_t                cond;
      logic [BR_W-1:0]      a;
      logic [BR_W-1:0]      b;
      logic [BR_ADDR_W-1:0] pc;
      logic [BR_ADDR_W-1:0] target;
      logic                 pred_taken;
   } s1_pl_t;

   typedef struct packed {
      logic                 taken;
      logic                 mispredict;
      logic [BR_ADDR_W-1:0] redirect_pc;
   } s2_res_t;

   function automatic logic [BR_ADDR_W-1:0] seq_pc(input logic [BR_ADDR_W-1:0] pc);
      return pc + BR_ADDR_W'(BR_INSN_BYTES);
   endfunction

endpackage

// File: rtl/br_resolve_cmp.sv
// rtl/br_resolve_cmp.sv - W-bit magnitude comparator, signed or unsigned by parameter
//
// Parameters:
//   W         - operand width
//   IS_SIGNED - 1: two's-complement compare, 0: unsigned compare
// Ports:
//   a, b       - operands (exactly W bits, no extension)
//   eq, gt, lt - a == b, a > b, a < b

module br_resolve_cmp #(
   parameter int W         = 32,
   parameter bit IS_SIGNED = 1'b0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         gt,
   output logic         lt
);

   always_comb begin
      eq = (a == b);
      if (IS_SIGNED) begin
         gt = ($signed(a) > $signed(b));
         lt = ($signed(a) < $signed(b));
      end else begin
         gt = (a > b);
         lt = (a < b);
      end
   end

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - two-stage branch resolution with valid/ready handshake and squash
//
// Optional feature macro: BR_RESOLVE_STATS_EN (adds o_br_cnt / o_mispred_cnt)
// Ports:
//   clk, arst_n        - clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready   - input handshake for a branch op
//   i_cond             - condition code (cond_t encoding)
//   i_a, i_b           - operands
//   i_pc, i_target     - branch PC and taken target
//   i_pred_taken       - front-end direction prediction
//   i_flush            - kill everything in flight, highest priority
//   o_valid, i_ready   - output handshake for the resolved result
//   o_taken            - resolved direction
//   o_mispredict       - resolved direction differs from prediction
//   o_redirect_pc      - taken ? target : pc + 4
//   o_br_cnt           - (stats build) saturating count of result handshakes
//   o_mispred_cnt      - (stats build) saturating count of mispredicting handshakes

module br_resolve
   import br_resolve_pkg::*;
#(
   parameter int W      = BR_W,
   parameter int ADDR_W = BR_ADDR_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_cond,
   input  logic [W-1:0]      i_a,
   input  logic [W-1:0]      i_b,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_target,
   input  logic              i_pred_taken,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_taken,
   output logic              o_mispredict,
   output logic [ADDR_W-1:0] o_redirect_pc
`ifdef BR_RESOLVE_STATS_EN
   ,
   output logic [31:0]       o_br_cnt,
   output logic [31:0]       o_mispred_cnt
`endif
);

   s1_pl_t  s1_q;
   logic    s1_valid;
   s2_res_t s2_q;
   logic    s2_valid;
   s2_res_t res;

   logic s2_load, s1_advance, squash, accept, taken;
   logic s_eq, s_gt, s_lt, u_eq, u_gt, u_lt;
   logic cmp_unused;

   br_resolve_cmp #(.W(W), .IS_SIGNED(1'b1)) u_cmp_s (
      .a(s1_q.a), .b(s1_q.b), .eq(s_eq), .gt(s_gt), .lt(s_lt)
   );

   br_resolve_cmp #(.W(W), .IS_SIGNED(1'b0)) u_cmp_u (
      .a(s1_q.a), .b(s1_q.b), .eq(u_eq), .gt(u_gt), .lt(u_lt)
   );

   // Equality is taken from the signed instance; the remaining flags are not needed.
   assign cmp_unused = s_gt ^ u_gt ^ u_eq;

   assign s2_load    = ~s2_valid | i_ready;
   assign s1_advance = s1_valid & s2_load;
   // A mispredict leaving S2 makes whatever sits in S1 wrong-path work.
   assign squash     = s2_valid & i_ready & s2_q.mispredict;
   assign o_ready    = (~s1_valid | s1_advance) & ~squash & ~i_flush;
   assign accept     = i_valid & o_ready;

   always_comb begin
      taken = 1'b0;
      case (s1_q.cond)
         COND_EQ:     taken = s_eq;
         COND_NE:     taken = ~s_eq;
         COND_ALWAYS: taken = 1'b1;
         COND_NEVER:  taken = 1'b0;
         COND_LT:     taken = s_lt;
         COND_GE:     taken = ~s_lt;
         COND_LTU:    taken = u_lt;
         COND_GEU:    taken = ~u_lt;
         default:     taken = 1'b0;
      endcase
      res.taken       = taken;
      res.mispredict  = taken ^ s1_q.pred_taken;
      res.redirect_pc = taken ? s1_q.target : seq_pc(s1_q.pc);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (i_flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_q     <= '{cond: cond_t'(i_cond), a: i_a, b: i_b, pc: i_pc,
                       target: i_target, pred_taken: i_pred_taken};
      end else if (s1_advance | squash) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s2_valid <= 1'b0;
         s2_q     <= '0;
      end else if (i_flush) begin
         s2_valid <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid & ~squash;
         if (s1_valid & ~squash) begin
            s2_q <= res;
         end
      end
   end

   assign o_valid       = s2_valid;
   assign o_taken       = s2_q.taken;
   assign o_mispredict  = s2_q.mispredict;
   assign o_redirect_pc = s2_q.redirect_pc;

`ifdef BR_RESOLVE_STATS_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_br_cnt      <= '0;
         o_mispred_cnt <= '0;
      end else if (s2_valid & i_ready) begin
         if (o_br_cnt != '1) begin
            o_br_cnt <= o_br_cnt + 32'd1;
         end
         if (s2_q.mispredict && (o_mispred_cnt != '1)) begin
            o_mispred_cnt <= o_mispred_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - scoreboard bench for br_resolve

module tb_br_resolve;

   logic        clk;
   logic        arst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_cond;
   logic [31:0] i_a, i_b, i_pc, i_target;
   logic        i_pred_taken;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic        o_taken;
   logic        o_mispredict;
   logic [31:0] o_redirect_pc;
`ifdef BR_RESOLVE_STATS_EN
   logic [31:0] o_br_cnt, o_mispred_cnt;
`endif

   typedef struct packed {
      logic        taken;
      logic        mis;
      logic [31:0] redir;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;

   br_resolve dut (
      .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_cond(i_cond), .i_a(i_a), .i_b(i_b), .i_pc(i_pc), .i_target(i_target),
      .i_pred_taken(i_pred_taken), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_taken(o_taken), .o_mispredict(o_mispredict),
      .o_redirect_pc(o_redirect_pc)
`ifdef BR_RESOLVE_STATS_EN
      , .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
      exp_t e;
      logic t;
      case (c)
         3'd0: t = (a == b);
         3'd1: t = (a != b);
         3'd2: t = 1'b1;
         3'd3: t = 1'b0;
         3'd4: t = ($signed(a) < $signed(b));
         3'd5: t = !($signed(a) < $signed(b));
         3'd6: t = (a < b);
         default: t = (a >= b);
      endcase
      e.taken = t;
      e.mis   = t ^ pred;
      e.redir = t ? tgt : pc + 32'd4;
      return e;
   endfunction

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (arst_n && !i_flush) begin
         if (o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected: got result taken=%0b redirect=%h, required no result",
                        o_taken, o_redirect_pc);
            end else begin
               mon_e = sb.pop_front();
               if ({o_taken, o_mispredict, o_redirect_pc} !== {mon_e.taken, mon_e.mis, mon_e.redir})
                  $display("FAIL sb_result: got taken=%0b mis=%0b redirect=%h, required taken=%0b mis=%0b redirect=%h",
                           o_taken, o_mispredict, o_redirect_pc, mon_e.taken, mon_e.mis, mon_e.redir);
               else
                  passed++;
               if (mon_e.mis) sb.delete();
            end
         end
         if (i_valid && o_ready)
            sb.push_back(model(i_cond, i_a, i_b, i_pc, i_target, i_pred_taken));
      end
   end

   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
      int n = 0;
      i_cond = c; i_a = a; i_b = b; i_pc = pc; i_target = tgt; i_pred_taken = pred;
      i_valid = 1'b1;
      @(negedge clk);
      while (!o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         checks++;
         $display("FAIL send_timeout: got o_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (sb.size() != 0 && n < 30);
      #1;
      checks++;
      if (sb.size() != 0)
         $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
      else
         passed++;
   endtask

   task automatic test_reset();
      arst_n = 1'b0; i_valid = 1'b0; i_cond = 3'd0; i_a = '0; i_b = '0; i_pc = '0;
      i_target = '0; i_pred_taken = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      #3;
      checks += 5;
      if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b required 0", o_valid); else passed++;
      if (o_ready !== 1'b1) $display("FAIL reset_o_ready: got %b required 1", o_ready); else passed++;
      if (o_taken !== 1'b0) $display("FAIL reset_o_taken: got %b required 0", o_taken); else passed++;
      if (o_mispredict !== 1'b0) $display("FAIL reset_o_mispredict: got %b required 0", o_mispredict); else passed++;
      if (o_redirect_pc !== 32'h0) $display("FAIL reset_redirect: got %h required 0", o_redirect_pc); else passed++;
      @(posedge clk); @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_beq();
      i_ready = 1'b1;
      send(3'd0, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) $display("FAIL beq_early: got o_valid=%b required 0", o_valid); else passed++;
      @(negedge clk);
      checks++;
      if ({o_valid, o_taken, o_mispredict, o_redirect_pc} !== {3'b111, 32'h200})
         $display("FAIL beq_result: got v=%b t=%b m=%b pc=%h required v=1 t=1 m=1 pc=00000200",
                  o_valid, o_taken, o_mispredict, o_redirect_pc);
      else passed++;
      @(posedge clk); #1;
      drain("beq");
   endtask

   task automatic test_blt_bltu();
      i_ready = 1'b1;
      send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h480, 1'b1);
      send(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h404, 32'h500, 1'b1);
      @(negedge clk);
      checks++;
      if ({o_valid, o_taken} !== 2'b11) $display("FAIL blt_taken: got v=%b t=%b required v=1 t=1", o_valid, o_taken);
      else passed++;
      @(negedge clk);
      checks++;
      if ({o_valid, o_taken, o_redirect_pc} !== {2'b10, 32'h408})
         $display("FAIL bltu_result: got v=%b t=%b pc=%h required v=1 t=0 pc=00000408", o_valid, o_taken, o_redirect_pc);
      else passed++;
      @(posedge clk); #1;
      drain("blt");
   endtask

   task automatic test_wrap();
      i_ready = 1'b1;
      send(3'd1, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h40, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({o_valid, o_taken, o_mispredict, o_redirect_pc} !== {3'b100, 32'h0})
         $display("FAIL wrap_result: got v=%b t=%b m=%b pc=%h required v=1 t=0 m=0 pc=00000000",
                  o_valid, o_taken, o_mispredict, o_redirect_pc);
      else passed++;
      @(posedge clk); #1;
      drain("wrap");
   endtask

   task automatic test_back_to_back();
      i_ready = 1'b0;
      send(3'd2, 32'd0, 32'd0, 32'h1000, 32'h2000, 1'b1);
      send(3'd3, 32'd0, 32'd0, 32'h1004, 32'h2800, 1'b0);
      i_cond = 3'd5; i_a = 32'hFFFF_FFFD; i_b = 32'hFFFF_FFFB; i_pc = 32'h1008;
      i_target = 32'h3000; i_pred_taken = 1'b1; i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks += 2;
         if (o_ready !== 1'b0) $display("FAIL bp_o_ready_%0d: got %b required 0", k, o_ready); else passed++;
         if ({o_valid, o_taken, o_mispredict, o_redirect_pc} !== {3'b110, 32'h2000})
            $display("FAIL bp_hold_%0d: got v=%b t=%b m=%b pc=%h required v=1 t=1 m=0 pc=00002000",
                     k, o_valid, o_taken, o_mispredict, o_redirect_pc);
         else passed++;
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) $display("FAIL bp_release: got o_ready=%b required 1", o_ready); else passed++;
      @(posedge clk); #1;
      i_valid = 1'b0;
      send(3'd7, 32'd3, 32'hFFFF_FFF0, 32'h100C, 32'h4000, 1'b0);
      drain("bp");
   endtask

   task automatic test_squash();
      i_ready = 1'b0;
      send(3'd0, 32'd1, 32'd1, 32'h2000, 32'h2100, 1'b0);
      send(3'd3, 32'd0, 32'd0, 32'h2004, 32'h2200, 1'b0);
      i_cond = 3'd2; i_a = '0; i_b = '0; i_pc = 32'h2008; i_target = 32'h7777_0000;
      i_pred_taken = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (o_ready !== 1'b0) $display("FAIL squash_o_ready: got %b required 0", o_ready); else passed++;
      if ({o_valid, o_mispredict} !== 2'b11)
         $display("FAIL squash_mis: got v=%b m=%b required v=1 m=1", o_valid, o_mispredict);
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      checks += 2;
      if (o_valid !== 1'b0) $display("FAIL squash_dropped: got o_valid=%b required 0", o_valid); else passed++;
      if (o_ready !== 1'b1) $display("FAIL squash_accept: got o_ready=%b required 1", o_ready); else passed++;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) $display("FAIL squash_latency: got o_valid=%b required 0", o_valid); else passed++;
      @(negedge clk);
      checks++;
      if ({o_valid, o_redirect_pc} !== {1'b1, 32'h7777_0000})
         $display("FAIL squash_next: got v=%b pc=%h required v=1 pc=77770000", o_valid, o_redirect_pc);
      else passed++;
      @(posedge clk); #1;
      drain("squash");
   endtask

   task automatic test_flush();
      i_ready = 1'b0;
      send(3'd2, 32'd0, 32'd0, 32'h3000, 32'h3100, 1'b1);
      send(3'd3, 32'd0, 32'd0, 32'h3004, 32'h3200, 1'b0);
      i_cond = 3'd2; i_pc = 32'h3008; i_target = 32'h3300; i_pred_taken = 1'b1;
      i_valid = 1'b1; i_flush = 1'b1;
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b0) $display("FAIL flush_o_ready: got %b required 0", o_ready); else passed++;
      @(posedge clk); #1;
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b0) $display("FAIL flush_o_valid_%0d: got %b required 0", k, o_valid); else passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      i_ready = 1'b0;
      send(3'd2, 32'd0, 32'd0, 32'h5000, 32'h5100, 1'b0);
      send(3'd2, 32'd0, 32'd0, 32'h5004, 32'h5200, 1'b1);
      #2;
      arst_n = 1'b0;
      #1;
      checks += 5;
      if (o_valid !== 1'b0) $display("FAIL arst_o_valid: got %b required 0", o_valid); else passed++;
      if (o_ready !== 1'b1) $display("FAIL arst_o_ready: got %b required 1", o_ready); else passed++;
      if (o_taken !== 1'b0) $display("FAIL arst_o_taken: got %b required 0", o_taken); else passed++;
      if (o_mispredict !== 1'b0) $display("FAIL arst_o_mispredict: got %b required 0", o_mispredict); else passed++;
      if (o_redirect_pc !== 32'h0) $display("FAIL arst_redirect: got %h required 0", o_redirect_pc); else passed++;
      @(posedge clk); #1;
      arst_n = 1'b1;
      sb.delete();
      i_ready = 1'b1;
      @(posedge clk); #1;
   endtask

`ifdef BR_RESOLVE_STATS_EN
   task automatic test_stats();
      checks++;
      if ({o_br_cnt, o_mispred_cnt} !== 64'h0)
         $display("FAIL stats_reset: got br=%0d mis=%0d required 0 0", o_br_cnt, o_mispred_cnt);
      else passed++;
      i_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         send(3'd2, 32'd0, 32'd0, 32'h6000 + 32'(k * 4), 32'h6800, (k == 1 || k == 3) ? 1'b0 : 1'b1);
         drain("stats");
      end
      checks++;
      if ({o_br_cnt, o_mispred_cnt} !== {32'd5, 32'd2})
         $display("FAIL stats_count: got br=%0d mis=%0d required 5 2", o_br_cnt, o_mispred_cnt);
      else passed++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_beq();
      test_blt_bltu();
      test_wrap();
      test_back_to_back();
      test_squash();
      test_flush();
      test_async_reset();
`ifdef BR_RESOLVE_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
